// File: rtl/sum_bin_collector.sv
// Turns per-bin FFT power sums into bar heights and publishes whole frames
// through a double-buffered height memory read by the display.
module sum_bin_collector #(
  parameter int N         = 1024,
  parameter int fp_width  = 32,
  parameter int mag_width = 9,
  parameter int MAX_X     = 640,
  parameter int MAX_Y     = 480
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sum_done,
  input  logic [fp_width-1:0]  sum_data_out,
  input  logic                 frame_clear,
  input  logic [9:0]           rd_x,
  output logic [mag_width-1:0] rd_height,
  output logic                 frame_ready,
  output logic                 frame_valid
);
  localparam int               IDX_W     = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] STORE_LIM = IDX_W'(MAX_X);
  localparam logic [9:0]       RD_LIM    = 10'(MAX_X);
  localparam logic [9:0]       CLAMP_H   = 10'(MAX_Y - 1);

  // Height is the log2 of the power in quarter-octave steps: exponent plus two mantissa bits.
  function automatic logic [mag_width-1:0] fp_to_height(input logic [fp_width-1:0] f);
    logic       sgn;
    logic [7:0] ex;
    logic [9:0] raw;
    sgn = f[fp_width-1];
    ex  = f[fp_width-2 -: 8];
    raw = {ex - 8'd127, f[fp_width-10 -: 2]};
    if (sgn || (ex < 8'd127)) begin
      fp_to_height = '0;
    end else if ((ex == 8'hFF) || (raw > CLAMP_H)) begin
      fp_to_height = mag_width'(CLAMP_H);
    end else begin
      fp_to_height = mag_width'(raw);
    end
  endfunction

  logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0]     s1_idx_q, s1_idx_d;
  logic [mag_width-1:0] s1_height_q, s1_height_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 frame_ready_q, frame_ready_d;
  logic                 frame_valid_q, frame_valid_d;
  logic [mag_width-1:0] rd_height_q, rd_height_d;
  logic                 swap_s;
  logic [mag_width-1:0] bank0_q [MAX_X];
  logic [mag_width-1:0] bank1_q [MAX_X];

  // Low mantissa bits are below the height resolution.
  logic unused_mant_s;
  assign unused_mant_s = ^sum_data_out[fp_width-12:0];

  // Next-state: stage-1 capture, write counter, bank swap and display read.
  always_comb begin
    wr_idx_d    = wr_idx_q;
    s1_valid_d  = 1'b0;
    s1_idx_d    = s1_idx_q;
    s1_height_d = s1_height_q;
    if (frame_clear) begin
      wr_idx_d = '0;
    end else if (sum_done) begin
      s1_valid_d  = 1'b1;
      s1_idx_d    = wr_idx_q;
      s1_height_d = fp_to_height(sum_data_out);
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d = '0;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end else begin
      s1_valid_d = 1'b0;
    end

    // A last-bin write still completes under frame_clear but never publishes.
    swap_s        = s1_valid_q && (s1_idx_q == LAST_IDX) && !frame_clear;
    wr_bank_d     = wr_bank_q ^ swap_s;
    frame_valid_d = frame_valid_q | swap_s;
    frame_ready_d = swap_s;

    if (frame_valid_q && (rd_x < RD_LIM)) begin
      if (wr_bank_q) begin
        rd_height_d = bank0_q[rd_x];
      end else begin
        rd_height_d = bank1_q[rd_x];
      end
    end else begin
      rd_height_d = '0;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_idx_q      <= '0;
      s1_valid_q    <= 1'b0;
      s1_idx_q      <= '0;
      s1_height_q   <= '0;
      wr_bank_q     <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_valid_q <= 1'b0;
      rd_height_q   <= '0;
    end else begin
      wr_idx_q      <= wr_idx_d;
      s1_valid_q    <= s1_valid_d;
      s1_idx_q      <= s1_idx_d;
      s1_height_q   <= s1_height_d;
      wr_bank_q     <= wr_bank_d;
      frame_ready_q <= frame_ready_d;
      frame_valid_q <= frame_valid_d;
      rd_height_q   <= rd_height_d;
    end
  end

  // Stage-2 write into the bank currently being filled.
  always_ff @(posedge clk) begin
    if (rst && s1_valid_q && (s1_idx_q < STORE_LIM)) begin
      if (wr_bank_q) begin
        bank1_q[s1_idx_q] <= s1_height_q;
      end else begin
        bank0_q[s1_idx_q] <= s1_height_q;
      end
    end
  end

  assign rd_height   = rd_height_q;
  assign frame_ready = frame_ready_q;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_sum_bin_collector.sv
// Self-checking bench for sum_bin_collector: conversion table, frame scenarios
// and randomized traffic against a frame-level reference model.
module tb_sum_bin_collector;
  localparam int N     = 1024;
  localparam int MAX_X = 640;
  localparam int MAXH  = 479;
  localparam int NT    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sum_done = 1'b0;
  logic [31:0] sum_data_out = 32'd0;
  logic        frame_clear = 1'b0;
  logic [9:0]  rd_x = 10'd0;
  logic [8:0]  rd_height;
  logic        frame_ready;
  logic        frame_valid;

  always #5 clk = ~clk;

  sum_bin_collector dut (
    .clk(clk), .rst(rst), .sum_done(sum_done), .sum_data_out(sum_data_out),
    .frame_clear(frame_clear), .rd_x(rd_x), .rd_height(rd_height),
    .frame_ready(frame_ready), .frame_valid(frame_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Height straight from the format rule: 4*(e-127) + top two mantissa bits.
  function automatic int ref_height(input logic [31:0] f);
    int e;
    int m;
    int h;
    e = int'(f[30:23]);
    m = int'(f[22:21]);
    if (f[31] || e < 127) return 0;
    if (e == 255) return MAXH;
    h = (e - 127) * 4 + m;
    return (h > MAXH) ? MAXH : h;
  endfunction

  // Frame-level model: accepted samples fill cur; a completed frame is published one edge later.
  int  m_cur [MAX_X];
  int  m_disp[MAX_X];
  int  m_cnt   = 0;
  bit  m_pend  = 1'b0;
  int  m_rd    = 0;
  bit  m_ready = 1'b0;
  bit  m_valid = 1'b0;
  bit  chk_en  = 1'b0;
  int  ready_cnt = 0;

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      m_rd = 0; m_ready = 1'b0; m_valid = 1'b0; m_cnt = 0; m_pend = 1'b0;
    end else begin
      m_rd = (m_valid && int'(rd_x) < MAX_X) ? m_disp[int'(rd_x)] : 0;
      m_ready = 1'b0;
      if (m_pend && !frame_clear) begin
        m_disp  = m_cur;
        m_valid = 1'b1;
        m_ready = 1'b1;
      end
      m_pend = 1'b0;
      if (frame_clear) begin
        m_cnt = 0;
      end else if (sum_done) begin
        if (m_cnt < MAX_X) m_cur[m_cnt] = ref_height(sum_data_out);
        if (m_cnt == N - 1) begin
          m_pend = 1'b1;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (frame_ready) ready_cnt++;
    if (chk_en) begin
      check("model rd_height", int'(rd_height), m_rd);
      check("model frame_ready", int'(frame_ready), int'(m_ready));
      check("model frame_valid", int'(frame_valid), int'(m_valid));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] d);
    sum_done = 1'b1;
    sum_data_out = d;
    step();
    sum_done = 1'b0;
  endtask

  task automatic expect_ready(input string name);
    int lat;
    lat = 1;
    while (!frame_ready && lat < 10) begin
      step();
      lat++;
    end
    check(name, lat, 2);
  endtask

  task automatic read_chk(input string name, input int x, input int exp);
    rd_x = 10'(x);
    step();
    check(name, int'(rd_height), exp);
  endtask

  function automatic logic [31:0] pow_val(input int k, input int off, input logic [1:0] m);
    logic [7:0] e;
    e = 8'(127 + ((k + off) % 64));
    return {1'b0, e, m, 21'd0};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom();
    if ($urandom_range(0, 3) != 0) begin
      r[31]    = ($urandom_range(0, 9) == 0);
      r[30:23] = 8'($urandom_range(110, 255));
    end
    return r;
  endfunction

  typedef struct {
    logic [31:0] data;
    int          exp_h;
  } conv_vec_t;

  conv_vec_t tbl[NT];
  int        base;
  int        x;

  initial begin
    tbl[0]  = '{32'h3F800000, 0};
    tbl[1]  = '{32'h41000000, 12};
    tbl[2]  = '{32'h41400000, 14};
    tbl[3]  = '{32'h7F7FFFFF, 479};
    tbl[4]  = '{32'hC1000000, 0};
    tbl[5]  = '{32'h3E800000, 0};
    tbl[6]  = '{32'h7F800000, 479};
    tbl[7]  = '{32'h7FC00000, 479};
    tbl[8]  = '{32'hFF800000, 0};
    tbl[9]  = '{32'h40000000, 4};
    tbl[10] = '{32'h40600000, 7};
    tbl[11] = '{32'h42F00000, 27};
    tbl[12] = '{32'h7A000000, 468};
    tbl[13] = '{32'h7B600000, 479};
    tbl[14] = '{32'h7B800000, 479};
    tbl[15] = '{32'h00000000, 0};

    // Reset state
    repeat (3) step();
    check("reset rd_height", int'(rd_height), 0);
    check("reset frame_ready", int'(frame_ready), 0);
    check("reset frame_valid", int'(frame_valid), 0);
    rst = 1'b1;
    chk_en = 1'b1;

    // Conversion table carried in the first bins of one frame
    for (int k = 0; k < N; k++) send((k < NT) ? tbl[k].data : rand_fp());
    expect_ready("conv frame_ready latency");
    for (int i = 0; i < NT; i++) read_chk($sformatf("conv[%0d]", i), i, tbl[i].exp_h);

    // Full frame of power-of-two sums
    for (int k = 0; k < N; k++) send(pow_val(k, 0, 2'b00));
    expect_ready("full frame_ready latency");
    foreach (tbl[i]) begin
      x = (i * 97) % MAX_X;
      read_chk($sformatf("full rd_x=%0d", x), x, (x % 64) * 4);
    end
    read_chk("full rd_x=639", 639, (639 % 64) * 4);
    read_chk("full rd_x=640", 640, 0);
    read_chk("full rd_x=1023", 1023, 0);

    // Frame 2 writes must not disturb the displayed frame 1
    for (int k = 0; k < N; k++) begin
      x = k % 641;
      rd_x = 10'(x);
      send(pow_val(k, 5, 2'(k)));
      check("dbuf hold", int'(rd_height), (x < MAX_X) ? (x % 64) * 4 : 0);
    end
    expect_ready("dbuf frame_ready latency");
    read_chk("dbuf new rd_x=10", 10, ((10 + 5) % 64) * 4 + 2);
    read_chk("dbuf new rd_x=63", 63, ((63 + 5) % 64) * 4 + 3);

    // frame_clear together with sum_done at bin 300
    for (int k = 0; k < 300; k++) send(rand_fp());
    frame_clear = 1'b1;
    send(rand_fp());
    frame_clear = 1'b0;
    base = ready_cnt;
    for (int k = 0; k < N - 1; k++) send(rand_fp());
    repeat (3) step();
    check("clear no early ready", ready_cnt - base, 0);
    send(rand_fp());
    repeat (4) step();
    check("clear one ready", ready_cnt - base, 1);

    // Reset mid-frame at bin 500
    for (int k = 0; k < 500; k++) send(rand_fp());
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midreset frame_valid", int'(frame_valid), 0);
    for (int i = 0; i < 1024; i++) read_chk("midreset rd_height", i, 0);
    for (int k = 0; k < N; k++) send(rand_fp());
    expect_ready("midreset frame_ready latency");
    check("midreset frame_valid after", int'(frame_valid), 1);

    // Gapped input: sum_done every other cycle for 4*N cycles
    base = ready_cnt;
    for (int c = 0; c < 4 * N; c++) begin
      rd_x = 10'($urandom_range(0, 1023));
      if (c % 2 == 0) send(rand_fp());
      else step();
    end
    repeat (4) step();
    check("gapped ready count", ready_cnt - base, 2);

    // Random traffic with occasional clears and resets
    for (int c = 0; c < 3000; c++) begin
      rd_x         = 10'($urandom_range(0, 1023));
      frame_clear  = ($urandom_range(0, 399) == 0);
      rst          = ($urandom_range(0, 1499) != 0);
      sum_done     = ($urandom_range(0, 3) != 0);
      sum_data_out = rand_fp();
      step();
    end
    rst = 1'b1;
    frame_clear = 1'b0;
    sum_done = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sum_bin_collector.md
SUM_BIN_COLLECTOR -- requirements
Module: sum_bin_collector

Interface
REQ-001 SHALL have parameter N, default 1024: sums per frame (FFT bins).
REQ-002 SHALL have parameter fp_width, default 32: IEEE-754 single-precision sum width.
REQ-003 SHALL have parameter mag_width, default 9: bar height width.
REQ-004 SHALL have parameters MAX_X = 640 (bins stored/displayed) and MAX_Y = 480 (height clamp bound).
REQ-005 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port sum_done, input, 1: one-cycle strobe, sum_data_out valid.
REQ-008 SHALL have port sum_data_out, input, fp_width: real^2 + imag^2 of current bin.
REQ-009 SHALL have port frame_clear, input, 1: abandon partial frame, restart at bin 0.
REQ-010 SHALL have port rd_x, input, 10: display column to read.
REQ-011 SHALL have port rd_height, output, mag_width: bar height for rd_x.
REQ-012 SHALL have port frame_ready, output, 1: one-cycle pulse, new frame published.
REQ-013 SHALL have port frame_valid, output, 1: high once at least one frame published.

Function
REQ-014 SHALL convert sum_data_out (sign s, exponent e, mantissa m) to a height: 0 if s=1 or e<127; else ((e-127)<<2) | m[22:21], clamped to MAX_Y-1.
REQ-015 SHALL treat e=255 (Inf/NaN) with s=0 as clamp value MAX_Y-1.
REQ-016 SHALL register {height, wr_idx} when sum_done=1 (stage 1), and write the height to the write bank at that index on the next edge (stage 2); sum_done accepted every cycle, no stall.
REQ-017 SHALL keep write counter wr_idx, 0..N-1, incremented per accepted sum_done, wrapping N-1 -> 0.
REQ-018 SHALL write only indices 0..MAX_X-1; indices MAX_X..N-1 counted but discarded.
REQ-019 SHALL double-buffer: two banks of MAX_X x mag_width; wr_bank selects write bank, display bank is ~wr_bank.
REQ-020 SHALL, on the edge the stage-2 write of index N-1 completes, toggle wr_bank, set frame_valid=1, and assert frame_ready for exactly the following cycle.
REQ-021 SHALL return rd_height one cycle after rd_x from the display bank; 0 if rd_x >= MAX_X or frame_valid=0.
REQ-022 SHALL, on frame_clear=1, set wr_idx=0 and invalidate stage 1; no bank swap, display bank untouched; frame_clear wins over a simultaneous sum_done (sample dropped).
REQ-023 SHALL complete a stage-2 write already in flight when frame_clear asserts, but never swap for it.
REQ-024 SHALL NOT glitch rd_height on swap: a read issued in the swap cycle returns the pre-swap display bank.

Reset
REQ-025 SHALL, with rst=0 at a rising edge, set wr_idx=0, wr_bank=0, stage-1 valid=0, frame_ready=0, frame_valid=0, rd_height=0.
REQ-026 SHALL discard a partial frame on reset mid-frame; bank contents need not be cleared (masked by frame_valid=0).

Verification
REQ-027 SHALL check conversion: single bin sums 0x3F800000 -> 0, 0x41000000 -> 12, 0x41400000 -> 14, 0x7F7FFFFF -> 479, 0xC1000000 -> 0, 0x3E800000 -> 0.
REQ-028 SHALL check full frame: N back-to-back sum_done with bin k = 2^k-style value e=127+(k mod 64) -> frame_ready one pulse, 2 cycles after last sum_done; rd_x=k reads ((k mod 64)<<2), clamped to 479; rd_x=640 -> 0.
REQ-029 SHALL check double-buffering: during frame 2 writes, rd_x sweep returns frame 1 data unchanged until frame 2 frame_ready.
REQ-030 SHALL check frame_clear at bin 300 together with sum_done -> bin dropped, no frame_ready; N further sums -> exactly one frame_ready.
REQ-031 SHALL check reset mid-frame at bin 500 -> frame_valid=0, rd_height=0 for all rd_x; next N sums -> frame_ready, frame_valid=1.
REQ-032 SHALL check gapped input: sum_done toggling every other cycle (4*N cycles) -> frame_ready exactly twice.
